// File: rtl/stream_select_framesync.sv
// stream_select_framesync: picks one of NCH pixel streams, switching channel only
// between frames, and tags each forwarded pixel with its row/column position.
module stream_select_framesync #(
  parameter int NCH   = 9,
  parameter int W     = 8,
  parameter int SEL_W = 5,
  parameter int COLS  = 210,
  parameter int ROWS  = 150,
  parameter int CNT_W = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NCH*W-1:0]   din,
  input  logic [NCH-1:0]     valid,
  input  logic [SEL_W-1:0]   selector,
  output logic [W-1:0]       dout,
  output logic               validout,
  output logic [CNT_W-1:0]   rowcount,
  output logic [CNT_W-1:0]   colcount,
  output logic               frameend,
  output logic [SEL_W-1:0]   active_sel
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROWS - 1);

  // Position of the next pixel to be accepted in the current frame
  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] col;

  logic             acc_p0;
  logic [W-1:0]     pix_p0;
  logic             idle_p0;
  logic             last_p0;

  // Channel mux; an out-of-range selector code never matches, so nothing is accepted
  always_comb begin
    acc_p0 = 1'b0;
    pix_p0 = '0;
    for (int k = 0; k < NCH; k++) begin
      if (active_sel == SEL_W'(k)) begin
        acc_p0 = valid[k];
        pix_p0 = din[k*W +: W];
      end
    end
  end

  assign idle_p0 = (row == '0) && (col == '0);
  assign last_p0 = (row == ROW_LAST) && (col == COL_LAST);

  // ---- stage p0 -> output registers ----
  // Register the accepted pixel, advance the raster position, and retarget the
  // channel only while no pixel of the current frame has been taken yet
  always_ff @(posedge clock) begin
    if (reset) begin
      active_sel <= '0;
      row        <= '0;
      col        <= '0;
      dout       <= '0;
      validout   <= 1'b0;
      rowcount   <= '0;
      colcount   <= '0;
      frameend   <= 1'b0;
    end else begin
      validout <= acc_p0;
      frameend <= acc_p0 && last_p0;
      if (acc_p0) begin
        dout     <= pix_p0;
        rowcount <= row;
        colcount <= col;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      // The pixel on this edge already used the old channel; the new one applies
      // from the next pixel onward, which belongs to a locked frame
      if (idle_p0) begin
        active_sel <= selector;
      end
    end
  end

endmodule

// File: tb/tb_stream_select_framesync.sv
// Directed bench for stream_select_framesync (COLS=4, ROWS=3 build) with a
// queue-based scoreboard of expected per-cycle outputs.
module tb_stream_select_framesync;

  localparam int NCH   = 9;
  localparam int W     = 8;
  localparam int SEL_W = 5;
  localparam int COLS  = 4;
  localparam int ROWS  = 3;
  localparam int CNT_W = 10;

  logic               clock;
  logic               reset;
  logic [NCH*W-1:0]   din;
  logic [NCH-1:0]     valid;
  logic [SEL_W-1:0]   selector;
  logic [W-1:0]       dout;
  logic               validout;
  logic [CNT_W-1:0]   rowcount;
  logic [CNT_W-1:0]   colcount;
  logic               frameend;
  logic [SEL_W-1:0]   active_sel;

  stream_select_framesync #(
    .NCH(NCH), .W(W), .SEL_W(SEL_W), .COLS(COLS), .ROWS(ROWS), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .din(din), .valid(valid), .selector(selector),
    .dout(dout), .validout(validout), .rowcount(rowcount), .colcount(colcount),
    .frameend(frameend), .active_sel(active_sel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int dout;
    int vo;
    int row;
    int col;
    int fe;
    int sel;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // reference state
  int m_sel = 0, m_row = 0, m_col = 0;
  int m_dout = 0, m_rc = 0, m_cc = 0;

  function automatic logic [NCH*W-1:0] mk(input int p);
    logic [NCH*W-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) r[k*W +: W] = W'(k*16 + (p % 16));
    return r;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input logic rst_i, input logic [NCH-1:0] v,
                      input logic [SEL_W-1:0] s, input logic [NCH*W-1:0] d);
    exp_t e;
    int acc, px, idle;
    reset = rst_i; valid = v; selector = s; din = d;
    if (rst_i) begin
      m_sel = 0; m_row = 0; m_col = 0; m_dout = 0; m_rc = 0; m_cc = 0;
      e = '{dout: 0, vo: 0, row: 0, col: 0, fe: 0, sel: 0};
    end else begin
      acc = 0; px = 0;
      if (m_sel < NCH) begin
        acc = int'(v[m_sel]);
        px  = int'(d[m_sel*W +: W]);
      end
      e.vo = acc;
      e.fe = (acc == 1 && m_row == ROWS-1 && m_col == COLS-1) ? 1 : 0;
      if (acc == 1) begin m_dout = px; m_rc = m_row; m_cc = m_col; end
      idle = (m_row == 0 && m_col == 0) ? 1 : 0;
      if (acc == 1) begin
        if (m_col == COLS-1) begin
          m_col = 0;
          m_row = (m_row == ROWS-1) ? 0 : m_row + 1;
        end else m_col = m_col + 1;
      end
      if (idle == 1) m_sel = int'(s);
      e.dout = m_dout; e.row = m_rc; e.col = m_cc; e.sel = m_sel;
    end
    q.push_back(e);
    @(posedge clock);
    #1;
    e = q.pop_front();
    chk("validout",   int'(validout),   e.vo);
    chk("frameend",   int'(frameend),   e.fe);
    chk("dout",       int'(dout),       e.dout);
    chk("rowcount",   int'(rowcount),   e.row);
    chk("colcount",   int'(colcount),   e.col);
    chk("active_sel", int'(active_sel), e.sel);
  endtask

  localparam logic [NCH-1:0] V0   = NCH'(1);
  localparam logic [NCH-1:0] VALL = '1;

  initial begin
    int p;
    logic [SEL_W-1:0] s0;
    reset = 1'b1; valid = '0; selector = '0; din = '0;

    // reset state
    step(1'b1, '0, '0, '0);
    step(1'b1, '0, '0, '0);
    chk("reset_validout", int'(validout), 0);
    chk("reset_active_sel", int'(active_sel), 0);

    // 1: three pixels on ch0
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, V0, '0, mk(i));
      chk("t1_dout", int'(dout), i);
      chk("t1_col", int'(colcount), i - 1);
      chk("t1_row", int'(rowcount), 0);
    end

    // 2: rest of the frame, with a gap cycle
    for (int i = 4; i <= 12; i++) begin
      if (i == 7) step(1'b0, '0, '0, mk(99));
      step(1'b0, V0, '0, mk(i));
    end
    chk("t2_frameend", int'(frameend), 1);
    chk("t2_last_row", int'(rowcount), 2);
    chk("t2_last_col", int'(colcount), 3);
    step(1'b0, V0, '0, mk(13));
    chk("t2_next_row", int'(rowcount), 0);
    chk("t2_next_col", int'(colcount), 0);
    chk("t2_next_fe", int'(frameend), 0);

    // finish that frame so the block is idle
    for (int i = 14; i <= 24; i++) step(1'b0, V0, '0, mk(i));
    chk("t2_fe2", int'(frameend), 1);

    // 3: switch request after pixel 5 is deferred until after frameend
    for (int i = 1; i <= 5; i++) step(1'b0, VALL, '0, mk(i));
    for (int i = 6; i <= 12; i++) begin
      step(1'b0, VALL, SEL_W'(6), mk(i));
      chk("t3_sel_held", int'(active_sel), 0);
      chk("t3_dout_ch0", int'(dout[7:4]), 0);
    end
    chk("t3_frameend", int'(frameend), 1);
    step(1'b0, '0, SEL_W'(6), mk(0));
    chk("t3_sel_new", int'(active_sel), 6);
    step(1'b0, VALL, SEL_W'(6), mk(1));
    chk("t3_ch6_dout", int'(dout), 8'h61);
    chk("t3_ch6_row", int'(rowcount), 0);
    chk("t3_ch6_col", int'(colcount), 0);
    for (int i = 2; i <= 12; i++) step(1'b0, VALL, SEL_W'(6), mk(i));

    // 4: illegal selector from reset, then select ch2
    step(1'b1, '0, SEL_W'(12), mk(0));
    step(1'b0, '0, SEL_W'(12), mk(0));
    chk("t4_sel12", int'(active_sel), 12);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, NCH'($urandom), SEL_W'(12), mk(i));
      chk("t4_silent", int'(validout), 0);
    end
    step(1'b0, '0, SEL_W'(2), mk(0));
    chk("t4_sel2", int'(active_sel), 2);
    step(1'b0, VALL, SEL_W'(2), mk(5));
    chk("t4_ch2_dout", int'(dout), 8'h25);
    chk("t4_ch2_vo", int'(validout), 1);

    // 5: reset at row 1 col 2
    for (int i = 6; i <= 11; i++) step(1'b0, VALL, SEL_W'(2), mk(i));
    chk("t5_pre_row", int'(rowcount), 1);
    chk("t5_pre_col", int'(colcount), 2);
    step(1'b1, VALL, SEL_W'(2), mk(12));
    chk("t5_rst_vo", int'(validout), 0);
    chk("t5_rst_row", int'(rowcount), 0);
    chk("t5_rst_col", int'(colcount), 0);
    chk("t5_rst_sel", int'(active_sel), 0);
    step(1'b0, VALL, SEL_W'(2), mk(3));
    chk("t5_fresh_dout", int'(dout), 8'h03);
    chk("t5_fresh_col", int'(colcount), 0);
    for (int i = 4; i <= 14; i++) step(1'b0, VALL, SEL_W'(2), mk(i));
    chk("t5_frameend", int'(frameend), 1);

    // 6: selector moving every cycle while all channels stream
    step(1'b0, '0, SEL_W'(4), mk(0));
    for (int i = 0; i < 14; i++) begin
      p = (i * 5 + 3) % NCH;
      if (i == 0) s0 = SEL_W'(p);
      step(1'b0, VALL, SEL_W'(p), mk(i));
      if (i == 0) chk("t6_first_ch", int'(dout[7:4]), 4);
      if (i >= 1 && i <= 11) begin
        chk("t6_locked_ch", int'(dout[7:4]), int'(s0));
        chk("t6_locked_sel", int'(active_sel), int'(s0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
